// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master to one-slave bus arbiter with hold-limit preemption.
//   Parameter MAX_HOLD (1..255): most consecutive owned cycles while the other master requests.
//   Ports:
//     clk, reset_n                         clock, asynchronous active-low reset
//     M0_req/M0_wr/M0_address/M0_dout      master 0 request, write strobe, address, write data
//     M1_req/M1_wr/M1_address/M1_dout      master 1 equivalents
//     M0_grant, M1_grant                   grants decoded from the registered state
//     S_req/S_wr/S_address/S_dout          shared bus driven by the current owner
//     S_din                                slave read data
//     M_din                                read data returned to both masters
//   Optional macro ROUND_ROBIN_EN: idle ties go to the master that did not win last;
//   without it, idle ties always go to master 0.
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_address,
    input  logic [31:0] M0_dout,
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M1_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic        S_req,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_dout,
    input  logic [31:0] S_din,
    output logic [31:0] M_din
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, next_state;
    logic [7:0] hold_cnt;
    logic other_req, limit, tie_m1;
    assign other_req = state == OWN0 ? M1_req : state == OWN1 ? M0_req : 1'b0;
    assign limit = other_req && hold_cnt == 8'(MAX_HOLD - 1);
`ifdef ROUND_ROBIN_EN
    logic last_m1;
    // Reset to master 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            last_m1 <= 1'b1;
        else if (next_state != state && next_state != IDLE)
            last_m1 <= next_state == OWN1;
    assign tie_m1 = !last_m1;
`else
    assign tie_m1 = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    // Counts owned cycles during which the other master waits; frozen while it does not.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            hold_cnt <= '0;
        else if (next_state != state)
            hold_cnt <= '0;
        else if (other_req && hold_cnt != 8'hff)
            hold_cnt <= hold_cnt + 8'd1;
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: next_state = (M0_req && M1_req) ? (tie_m1 ? OWN1 : OWN0) :
                               M0_req ? OWN0 : M1_req ? OWN1 : IDLE;
            OWN0: next_state = (M0_req && !limit) ? OWN0 : M1_req ? OWN1 : IDLE;
            OWN1: next_state = (M1_req && !limit) ? OWN1 : M0_req ? OWN0 : IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        M0_grant  = state == OWN0;
        M1_grant  = state == OWN1;
        S_req     = M0_grant ? M0_req     : M1_grant ? M1_req     : 1'b0;
        S_wr      = M0_grant ? M0_wr      : M1_grant ? M1_wr      : 1'b0;
        S_address = M0_grant ? M0_address : M1_grant ? M1_address : 8'h00;
        S_dout    = M0_grant ? M0_dout    : M1_grant ? M1_dout    : 32'h0;
        M_din     = S_din;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against an ownership model.
module tb_bus_arbiter;
    localparam int MAX_HOLD = 16;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b0;
    logic M0_req = 0, M0_wr = 0, M1_req = 0, M1_wr = 0;
    logic [7:0] M0_address = 0, M1_address = 0;
    logic [31:0] M0_dout = 0, M1_dout = 0, S_din = 0;
    logic M0_grant, M1_grant, S_req, S_wr;
    logic [7:0] S_address;
    logic [31:0] S_dout, M_din;
    int checks = 0, errors = 0;
    int m_owner = 0, m_held = 0;
    bit m_last_m1 = 1'b1;

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
        .M0_grant(M0_grant), .M1_grant(M1_grant),
        .S_req(S_req), .S_wr(S_wr), .S_address(S_address), .S_dout(S_dout),
        .S_din(S_din), .M_din(M_din)
    );

    always #5 clk = ~clk;

    // Ownership model: owner 0 = none, 1 = master 0, 2 = master 1; m_held counts owned
    // cycles in which the other master was waiting; reaching MAX_HOLD hands the bus over.
    task automatic model_edge();
        int nxt;
        bit own_r, oth_r;
        own_r = 0;
        oth_r = 0;
        if (!reset_n) begin
            m_owner = 0; m_held = 0; m_last_m1 = 1'b1;
            return;
        end
        if (m_owner == 0)
            nxt = (M0_req && M1_req) ? ((RR && !m_last_m1) ? 2 : 1) : M0_req ? 1 : M1_req ? 2 : 0;
        else begin
            own_r = m_owner == 1 ? M0_req : M1_req;
            oth_r = m_owner == 1 ? M1_req : M0_req;
            if (oth_r && m_held + 1 >= MAX_HOLD) nxt = 3 - m_owner;
            else if (own_r) nxt = m_owner;
            else if (oth_r) nxt = 3 - m_owner;
            else nxt = 0;
        end
        if (nxt != m_owner) begin
            m_held = 0;
            if (nxt != 0) m_last_m1 = nxt == 2;
        end else if (oth_r) m_held++;
        m_owner = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        {M0_req, M0_wr, M1_req, M1_wr} = '0;
        M0_address = 0; M1_address = 0; M0_dout = 0; M1_dout = 0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        M0_req = 1; M1_req = 1; M0_wr = 1; M0_address = 8'h5a; M0_dout = 32'hdeadbeef;
        #1;
        checks++;
        if ({M0_grant, M1_grant, S_req, S_wr} !== 4'b0 || S_address !== 8'h00 || S_dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got g0=%b g1=%b req=%b wr=%b addr=%h dout=%h, want all zero",
                     M0_grant, M1_grant, S_req, S_wr, S_address, S_dout);
        end
        tick();
        checks++;
        if ({M0_grant, M1_grant} !== 2'b0) begin
            errors++;
            $display("FAIL reset_hold: got g0=%b g1=%b, want 0 0", M0_grant, M1_grant);
        end
        do_reset();
    endtask

    task automatic test_write_grant();
        M0_req = 1; M0_wr = 1; M0_address = 8'h4b; M0_dout = 32'h0;
        #1;
        checks++;
        if (M0_grant !== 1'b0) begin
            errors++;
            $display("FAIL grant_latency: got M0_grant=%b before edge, want 0", M0_grant);
        end
        tick();
        checks++;
        if (M0_grant !== 1'b1 || M1_grant !== 1'b0 || S_address !== 8'h4b || S_wr !== 1'b1 || S_req !== 1'b1) begin
            errors++;
            $display("FAIL write_grant: got g0=%b g1=%b addr=%h wr=%b req=%b, want 1 0 4b 1 1",
                     M0_grant, M1_grant, S_address, S_wr, S_req);
        end
    endtask

    task automatic test_read_passthrough();
        M0_wr = 0; M0_address = 8'h02; S_din = 32'h07;
        #1;
        checks++;
        if (M_din !== 32'h07 || S_wr !== 1'b0 || S_address !== 8'h02) begin
            errors++;
            $display("FAIL read_path: got M_din=%h wr=%b addr=%h, want 07 0 02", M_din, S_wr, S_address);
        end
        M0_req = 0;
        tick();
        checks++;
        if (M0_grant !== 1'b0 || S_req !== 1'b0 || S_address !== 8'h00) begin
            errors++;
            $display("FAIL release_idle: got g0=%b req=%b addr=%h, want 0 0 00", M0_grant, S_req, S_address);
        end
    endtask

    task automatic test_ties();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            bit want_m1;
            want_m1 = (k == 1) && RR;
            M0_req = 1; M1_req = 1;
            tick();
            checks++;
            if (M0_grant !== !want_m1 || M1_grant !== want_m1) begin
                errors++;
                $display("FAIL tie_%0d: got g0=%b g1=%b, want %b %b", k, M0_grant, M1_grant, !want_m1, want_m1);
            end
            repeat (2) tick();
            M0_req = 0; M1_req = 0;
            tick();
            checks++;
            if ({M0_grant, M1_grant} !== 2'b0) begin
                errors++;
                $display("FAIL tie_release_%0d: got g0=%b g1=%b, want 0 0", k, M0_grant, M1_grant);
            end
        end
    endtask

    task automatic test_preempt();
        int cnt;
        do_reset();
        M0_req = 1;
        tick();
        repeat (4) tick();
        M1_req = 1;
        cnt = 0;
        while (!M1_grant && cnt < 40) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt != MAX_HOLD) begin
            errors++;
            $display("FAIL preempt_delay: got %0d cycles, want %0d", cnt, MAX_HOLD);
        end
        checks++;
        if (M0_grant !== 1'b0 || M1_grant !== 1'b1) begin
            errors++;
            $display("FAIL preempt_swap: got g0=%b g1=%b, want 0 1", M0_grant, M1_grant);
        end
        M0_req = 0; M1_req = 0;
        tick();
    endtask

    task automatic test_handover_and_async_reset();
        do_reset();
        M0_req = 1; M0_address = 8'h11;
        tick();
        M1_req = 1; M1_wr = 1; M1_address = 8'hc3;
        tick();
        checks++;
        if (M0_grant !== 1'b1 || S_address !== 8'h11) begin
            errors++;
            $display("FAIL handover_pre: got g0=%b addr=%h, want 1 11", M0_grant, S_address);
        end
        M0_req = 0;
        tick();
        checks++;
        if (M1_grant !== 1'b1 || M0_grant !== 1'b0 || S_address !== 8'hc3 || S_wr !== 1'b1) begin
            errors++;
            $display("FAIL handover: got g0=%b g1=%b addr=%h wr=%b, want 0 1 c3 1", M0_grant, M1_grant, S_address, S_wr);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if (M1_grant !== 1'b0 || S_req !== 1'b0 || S_wr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got g1=%b req=%b wr=%b, want 0 0 0", M1_grant, S_req, S_wr);
        end
        M1_req = 0; M1_wr = 0;
        m_owner = 0; m_held = 0; m_last_m1 = 1'b1;
        #3 reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({M0_grant, M1_grant} !== 2'b0) begin
                errors++;
                $display("FAIL post_reset_idle_%0d: got g0=%b g1=%b, want 0 0", i, M0_grant, M1_grant);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic e_req, e_wr;
            logic [7:0] e_addr;
            logic [31:0] e_dout;
            if ($urandom_range(3) == 0) M0_req = ~M0_req;
            if ($urandom_range(3) == 0) M1_req = ~M1_req;
            M0_wr = 1'($urandom); M1_wr = 1'($urandom);
            M0_address = 8'($urandom); M1_address = 8'($urandom);
            M0_dout = $urandom; M1_dout = $urandom; S_din = $urandom;
            #1;
            e_req  = m_owner == 1 ? M0_req     : m_owner == 2 ? M1_req     : 1'b0;
            e_wr   = m_owner == 1 ? M0_wr      : m_owner == 2 ? M1_wr      : 1'b0;
            e_addr = m_owner == 1 ? M0_address : m_owner == 2 ? M1_address : 8'h00;
            e_dout = m_owner == 1 ? M0_dout    : m_owner == 2 ? M1_dout    : 32'h0;
            checks++;
            if (M0_grant !== (m_owner == 1) || M1_grant !== (m_owner == 2) || S_req !== e_req ||
                S_wr !== e_wr || S_address !== e_addr || S_dout !== e_dout || M_din !== S_din) begin
                errors++;
                $display("FAIL random_%0d: got g0=%b g1=%b req=%b wr=%b addr=%h dout=%h din=%h, want owner=%0d req=%b wr=%b addr=%h dout=%h din=%h",
                         i, M0_grant, M1_grant, S_req, S_wr, S_address, S_dout, M_din,
                         m_owner, e_req, e_wr, e_addr, e_dout, S_din);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_grant();
        test_read_passthrough();
        test_ties();
        test_preempt();
        test_handover_and_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum number of consecutive owned cycles while the other master is requesting; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 M0_req  input  1  master 0 bus request, level, held until the transfer sequence ends.
REQ-005 M0_wr  input  1  master 0 write strobe (1 = write, 0 = read).
REQ-006 M0_address  input  8  master 0 address.
REQ-007 M0_dout  input  32  master 0 write data.
REQ-008 M1_req, M1_wr, M1_address, M1_dout  input  1/1/8/32  master 1 equivalents of REQ-004..REQ-007.
REQ-009 M0_grant, M1_grant  output  1 each  registered grants, mutually exclusive.
REQ-010 S_req, S_wr  output  1 each  shared-bus request and write strobe to the slave.
REQ-011 S_address  output  8  shared-bus address.
REQ-012 S_dout  output  32  shared-bus write data.
REQ-013 S_din  input  32  slave read data.
REQ-014 M_din  output  32  read data returned to both masters; S_din passed through combinationally.

Function
REQ-015 FSM states: IDLE, OWN0, OWN1; grants decode directly from state (OWN0 -> M0_grant=1, OWN1 -> M1_grant=1).
REQ-016 Grant latency: one clock; a request sampled high in IDLE yields a grant on the next rising edge.
REQ-017 IDLE with only M0_req -> OWN0; only M1_req -> OWN1; both high -> winner per REQ-030/031; neither -> IDLE.
REQ-018 OWNx with own req high and hold limit not reached -> stay in OWNx.
REQ-019 OWNx with own req low: other req high -> OWNy directly (no IDLE cycle); otherwise -> IDLE.
REQ-020 8-bit hold counter clears on every state change and increments each cycle in OWNx while the other master requests; it saturates, with no wrap.
REQ-021 Counter == MAX_HOLD-1 while the other master requests -> preempt to OWNy on the next edge regardless of own req.
REQ-022 Counter holds its value, without increment, when the other master is not requesting.
REQ-023 Bus mux: in OWN0, S_req/S_wr/S_address/S_dout = M0_req/M0_wr/M0_address/M0_dout; in OWN1, the M1 equivalents.
REQ-024 Bus mux in IDLE: S_req=0, S_wr=0, S_address=8'h00, S_dout=32'h0.
REQ-025 Bus mux is combinational from state and inputs, with no added latency.
REQ-026 Requests deasserted and reasserted in the same cycle cannot occur (level inputs); a glitch-free single-cycle drop is treated as release.

Reset
REQ-027 reset_n low asynchronously forces state IDLE, hold counter 0, both grants 0, and the last-winner flag to 1 (master 1), so that master 0 wins the first tie.
REQ-028 Reset asserted mid-ownership drops the grant and bus strobes immediately, without waiting for a clock.
REQ-029 After reset_n rises, arbitration resumes on the first rising edge per REQ-017.

Configuration
REQ-030 Macro ROUND_ROBIN_EN defined: IDLE ties go to the master that did not receive the most recent grant (last-winner flag updated on every entry to OWNx).
REQ-031 Macro ROUND_ROBIN_EN undefined: IDLE ties always go to master 0; the last-winner flag is not implemented; preemption (REQ-021) is unchanged.

Verification
REQ-032 Reset then M0_req=1, M0_wr=1, M0_address=8'h4b, M0_dout=32'h00 -> M0_grant=1 one clock later; S_address=8'h4b, S_wr=1; M1_grant=0 throughout.
REQ-033 M0 owns, M0_wr=0, M0_address=8'h02, S_din=32'h07 -> M_din=32'h07 in the same cycle.
REQ-034 M0 and M1 both request from IDLE twice, each released after 3 cycles -> without ROUND_ROBIN_EN M0 wins both ties; with it, M0 wins the first and M1 the second.
REQ-035 M0 holds req for 40 cycles, M1 requests at cycle 5, MAX_HOLD=16 -> M1_grant rises exactly 16 cycles after M1_req is first sampled; M0_grant falls on the same edge.
REQ-036 M0 owns and M1 requests; M0 drops req -> M1_grant=1 on the next edge with no IDLE cycle; S_address switches to M1_address.
REQ-037 reset_n pulsed low mid-OWN1 between clock edges -> M1_grant, S_req, and S_wr go 0 immediately; after release with no requests, the state stays IDLE.
